ldst_ctrl: RTL and testbench
============================

Name: ldst_ctrl

Overview:
Load/store initiator that sits between the execute stage and the big-endian 16-bit data memory. It accepts one load or store request at a time and drives the memory's addr/enable/wr/data_in pins. It consumes data_out, err and wr_success from the memory. The memory only supports aligned words, so this block splits odd-address accesses into aligned word accesses: two reads for a load, and read-modify-write of two words for a store.

Parameters:
ADDR_W, 16, address width; wrap-around is modulo 2^ADDR_W.
ALLOW_UNALIGNED, 1, 1 = split odd-address accesses; 0 = reject them with resp_err and make no memory access.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request offered
req_ready  out  1  block can accept a request; high iff state==IDLE
req_wr  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_wdata  in  16  store data, big-endian (bits [15:8] go to the lower address)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  16  load data; 0 for stores and errors
resp_err  out  1  access failed
mem_addr  out  ADDR_W  always even when mem_enable=1
mem_enable  out  1  memory enable
mem_wr  out  1  memory write
mem_wdata  out  16  memory write data
mem_rdata  in  16  memory read data, combinational, same cycle
mem_err  in  1  memory alignment error
mem_wr_success  in  1  registered write acknowledge, valid the cycle after a write

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset state:
  - state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0.
  - Memory outputs are all 0; they are decoded combinationally from state, so they drop immediately when rst_n asserts.
- Request capture: on req_valid&req_ready, register wr, addr, wdata. Let A0 = addr & ~1 and A1 = A0+2 mod 2^ADDR_W.
- States: IDLE, RD0, RD1, WR0, WACK0, WR1, WACK1, RESP.
- Memory drive per state:
  - RD0: mem_addr=A0, enable=1, wr=0; capture mem_rdata into w0.
  - RD1: mem_addr=A1, enable=1, wr=0; capture mem_rdata into w1.
  - WR0 / WR1: enable=1, wr=1, mem_addr=A0 / A1, one cycle each.
  - WACKx: enable=0; sample mem_wr_success.
  - All other states: memory outputs are 0.
- Sequences (T = accept cycle; resp_valid is asserted in RESP):
  - Aligned load: RD0 → RESP. Response at T+2, rdata=w0.
  - Aligned store: WR0 (wdata=req_wdata) → WACK0 → RESP. Response at T+3.
  - Unaligned load: RD0 → RD1 → RESP. Response at T+3, rdata={w0[7:0], w1[15:8]}.
  - Unaligned store: RD0 → RD1 → WR0 (wdata={w0[15:8], d[15:8]}) → WACK0 → WR1 (wdata={d[7:0], w1[7:0]}) → WACK1 → RESP. Response at T+7.
  - Odd address with ALLOW_UNALIGNED=0: IDLE → RESP. Response at T+1 with resp_err=1; mem_enable is never asserted.
- Errors:
  - mem_err=1 in any RDx/WRx cycle, or mem_wr_success=0 in WACKx, jumps to RESP with resp_err=1 and resp_rdata=0.
  - Remaining accesses are skipped. A store that fails after WR0 leaves the first word written; that is accepted.
- RESP lasts exactly one cycle, then returns to IDLE. There is no response backpressure. req_ready goes high the cycle after RESP.
- Wrap: A0=0xFFFE gives A1=0x0000.
- Reset mid-operation: abort immediately; no response is produced; memory may hold a partial store.
- req_* inputs are ignored while req_ready=0.

Decomposition:
- Package ldst_pkg holds:
  - the ldst_state_e enum (IDLE…RESP);
  - localparams for the access word width (16) and byte width (8);
  - the byte-lane merge function for unaligned load/store data.
- No sub-module is required. The FSM plus datapath registers fit in one module; the merge logic lives in the package function.

Test Plan:
- Aligned load: mem[0x10]=0xAB, mem[0x11]=0xCD; load 0x0010 → resp at T+2, rdata=0xABCD, err=0; mem_addr=0x0010 for exactly one cycle.
- Unaligned load: additionally mem[0x12]=0xEF; load 0x0011 → mem_addr 0x0010 then 0x0012; resp at T+3, rdata=0xCDEF.
- Unaligned store: store 0x1234 to 0x0011 → mem[0x10]=0xAB, [0x11]=0x12, [0x12]=0x34, [0x13] unchanged; resp at T+7, err=0.
- Wrap load: mem[0xFFFF]=0x5A, mem[0x0000]=0xA5; load 0xFFFF → mem_addr 0xFFFE then 0x0000; rdata=0x5AA5.
- Errors:
  - ALLOW_UNALIGNED=0, load 0x0011 → resp at T+1, err=1, mem_enable never high.
  - Memory model forcing wr_success=0 on an aligned store → err=1 at T+3.
- Reset in WR0 of an unaligned store → mem_enable=0 the same cycle; no resp_valid; after rst_n release, req_ready=1 and an aligned load completes normally.

Source files
------------

// File: rtl/ldst_pkg.sv
// Shared types and helpers for the load/store initiator.
package ldst_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        WR0,
        WACK0,
        WR1,
        WACK1,
        RESP
    } ldst_state_e;

    // Builds a word from one byte of hi_src (upper result byte) and one byte of
    // lo_src (lower result byte). A *_lo_lane of 1 picks bits [7:0] of that
    // source, 0 picks bits [15:8]. Memory is big-endian, so bits [15:8] of a
    // word are the byte at the even address.
    function automatic logic [WORD_W-1:0] merge_bytes(
        input logic [WORD_W-1:0] hi_src,
        input logic              hi_lo_lane,
        input logic [WORD_W-1:0] lo_src,
        input logic              lo_lo_lane
    );
        logic [BYTE_W-1:0] hi_b;
        logic [BYTE_W-1:0] lo_b;
        hi_b = hi_lo_lane ? hi_src[BYTE_W-1:0] : hi_src[WORD_W-1:BYTE_W];
        lo_b = lo_lo_lane ? lo_src[BYTE_W-1:0] : lo_src[WORD_W-1:BYTE_W];
        return {hi_b, lo_b};
    endfunction

endpackage

// File: rtl/ldst_ctrl.sv
// Load/store initiator: accepts one request at a time, splits odd-address
// accesses into aligned word accesses and drives the 16-bit data memory.
module ldst_ctrl
    import ldst_pkg::*;
#(
    parameter int ADDR_W          = 16,
    parameter bit ALLOW_UNALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_err,
    input  logic              mem_wr_success
);

    ldst_state_e       state_q;
    ldst_state_e       state_d;
    logic              err_q;
    logic              err_d;

    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] w0_q;
    logic [WORD_W-1:0] w1_q;

    logic              odd_q;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic              in_resp;

    assign odd_q   = addr_q[0];
    assign a0      = {addr_q[ADDR_W-1:1], 1'b0};
    assign a1      = a0 + ADDR_W'(2);
    assign in_resp = (state_q == RESP);

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = in_resp;
    assign resp_err   = in_resp & err_q;

    // Load data only leaves the block on a successful load response.
    always_comb begin
        resp_rdata = '0;
        if (in_resp && !err_q && !wr_q) begin
            resp_rdata = odd_q ? merge_bytes(w0_q, 1'b1, w1_q, 1'b0) : w0_q;
        end
    end

    // Control state; reset aborts any access in flight without a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Request capture and read-word capture; no reset needed on data.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req_valid) begin
            wr_q    <= req_wr;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
        if (state_q == RD0) begin
            w0_q <= mem_rdata;
        end
        if (state_q == RD1) begin
            w1_q <= mem_rdata;
        end
    end

    // Next-state sequencing and memory pin decode; any memory fault skips
    // the remaining accesses and goes straight to an error response.
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_addr[0] && !ALLOW_UNALIGNED) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        // Only an aligned store can skip the read phase.
                        state_d = (req_wr && !req_addr[0]) ? WR0 : RD0;
                    end
                end
            end
            RD0: begin
                mem_enable = 1'b1;
                mem_addr   = a0;
                if (mem_err) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    state_d = odd_q ? RD1 : RESP;
                end
            end
            RD1: begin
                mem_enable = 1'b1;
                mem_addr   = a1;
                if (mem_err) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    state_d = wr_q ? WR0 : RESP;
                end
            end
            WR0: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = a0;
                mem_wdata  = odd_q ? merge_bytes(w0_q, 1'b0, wdata_q, 1'b0) : wdata_q;
                if (mem_err) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    state_d = WACK0;
                end
            end
            WACK0: begin
                if (!mem_wr_success) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    state_d = odd_q ? WR1 : RESP;
                end
            end
            WR1: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = a1;
                mem_wdata  = merge_bytes(wdata_q, 1'b1, w1_q, 1'b1);
                if (mem_err) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    state_d = WACK1;
                end
            end
            WACK1: begin
                state_d = RESP;
                if (!mem_wr_success) begin
                    err_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ldst_ctrl.sv
// Scoreboard bench for ldst_ctrl: byte-addressed memory model, reference
// model of load/store semantics, randomized traffic plus directed cases.
module tb_ldst_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [15:0] req_wdata = 16'h0;
    logic        req_ready, resp_valid, resp_err, mem_enable, mem_wr;
    logic [15:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_err, mem_wr_success;

    logic        na_req_valid = 1'b0;
    logic        na_req_ready, na_resp_valid, na_resp_err, na_mem_enable, na_mem_wr;
    logic [15:0] na_resp_rdata, na_mem_addr, na_mem_wdata;

    ldst_ctrl #(.ADDR_W(16), .ALLOW_UNALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .mem_wr_success(mem_wr_success)
    );

    ldst_ctrl #(.ADDR_W(16), .ALLOW_UNALIGNED(1'b0)) dut_na (
        .clk(clk), .rst_n(rst_n),
        .req_valid(na_req_valid), .req_ready(na_req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(na_resp_valid), .resp_rdata(na_resp_rdata), .resp_err(na_resp_err),
        .mem_addr(na_mem_addr), .mem_enable(na_mem_enable), .mem_wr(na_mem_wr),
        .mem_wdata(na_mem_wdata), .mem_rdata(16'hBEEF), .mem_err(1'b0),
        .mem_wr_success(1'b0)
    );

    // Memory model: big-endian byte array, combinational read, registered ack.
    logic [7:0]  mem [0:65535];
    logic        inj_rd_err = 1'b0;
    logic        inj_wfail = 1'b0;
    logic        bd_we = 1'b0;
    logic [15:0] bd_addr = 16'h0;
    logic [7:0]  bd_data = 8'h0;
    logic        wr_succ_q = 1'b0;

    always_comb mem_rdata = {mem[mem_addr], mem[mem_addr + 16'd1]};
    assign mem_err = (mem_enable && !mem_wr && inj_rd_err) || (mem_enable && mem_addr[0]);
    assign mem_wr_success = wr_succ_q;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_enable && mem_wr) begin
            mem[mem_addr]         <= mem_wdata[15:8];
            mem[mem_addr + 16'd1] <= mem_wdata[7:0];
        end
        wr_succ_q <= mem_enable && mem_wr && !inj_wfail;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [15:0]      rdata;
        logic             err;
        int               t_acc;
        int               lat;
        int               n;
        logic [3:0][15:0] a;
    } exp_t;

    exp_t        q[$];
    logic [15:0] trace[$];
    logic [7:0]  ref_mem [0:65535];

    // Reference semantics: byte-addressed memory, word = bytes a and a+1.
    task automatic model(input logic wr, input logic [15:0] a, input logic [15:0] d,
                         input bit rerr, input bit wfail, output exp_t e);
        logic [15:0] a0, a1;
        bit odd;
        odd = a[0];
        a0 = a & 16'hFFFE;
        a1 = a0 + 16'd2;
        e.rdata = 16'h0; e.err = 1'b0; e.n = 0; e.a = '0; e.lat = 0; e.t_acc = 0;
        if (!wr) begin
            e.a[0] = a0; e.a[1] = a1;
            if (rerr) begin
                e.err = 1'b1; e.lat = 2; e.n = 1;
            end else begin
                e.rdata = {ref_mem[a], ref_mem[a + 16'd1]};
                e.lat = odd ? 3 : 2;
                e.n = odd ? 2 : 1;
            end
        end else if (!odd) begin
            e.n = 1; e.a[0] = a0; e.lat = 3; e.err = wfail;
            ref_mem[a0] = d[15:8];
            ref_mem[a0 + 16'd1] = d[7:0];
        end else begin
            e.a[0] = a0; e.a[1] = a1; e.a[2] = a0; e.a[3] = a1;
            if (rerr) begin
                e.err = 1'b1; e.lat = 2; e.n = 1;
            end else if (wfail) begin
                e.err = 1'b1; e.lat = 5; e.n = 3;
                ref_mem[a] = d[15:8];
            end else begin
                e.lat = 7; e.n = 4;
                ref_mem[a] = d[15:8];
                ref_mem[a + 16'd1] = d[7:0];
            end
        end
    endtask

    // Monitor: collects memory addresses and checks each response.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (mem_enable) begin
                trace.push_back(mem_addr);
                chk("mem_addr_even", {31'h0, mem_addr[0]}, 32'h0);
            end
            if (resp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 32'h1, 32'h0);
                end else begin
                    e = q.pop_front();
                    chk("resp_rdata", {16'h0, resp_rdata}, {16'h0, e.rdata});
                    chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                    chk("resp_latency", cyc - e.t_acc, e.lat);
                    chk("n_mem_access", trace.size(), e.n);
                    for (int i = 0; i < e.n && i < trace.size(); i++)
                        chk("mem_addr_seq", {16'h0, trace[i]}, {16'h0, e.a[i]});
                end
                trace.delete();
            end
        end
    end

    logic na_en_seen = 1'b0;
    always @(negedge clk) if (na_mem_enable) na_en_seen <= 1'b1;

    task automatic poke(input logic [15:0] a, input logic [7:0] b);
        bd_we = 1'b1; bd_addr = a; bd_data = b;
        ref_mem[a] = b;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic do_req(input logic wr, input logic [15:0] a, input logic [15:0] d,
                          input bit rerr, input bit wfail);
        exp_t e;
        int waitc;
        waitc = 0;
        @(negedge clk);
        while (!req_ready && waitc < 50) begin @(negedge clk); waitc++; end
        if (!req_ready) chk("ready_timeout", 32'h0, 32'h1);
        inj_rd_err = rerr; inj_wfail = wfail;
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
        model(wr, a, d, rerr, wfail, e);
        e.t_acc = cyc;
        q.push_back(e);
        @(negedge clk);
        // While busy, request pins carry noise that must be ignored.
        waitc = 0;
        while (!req_ready && waitc < 20) begin
            req_valid = 1'($urandom); req_wr = 1'($urandom);
            req_addr = 16'($urandom); req_wdata = 16'($urandom);
            @(negedge clk);
            waitc++;
        end
        req_valid = 1'b0;
        if (!req_ready) chk("resp_timeout", 32'h0, 32'h1);
        inj_rd_err = 1'b0; inj_wfail = 1'b0;
    endtask

    initial begin
        int waitc;
        int mism;
        logic [15:0] ra;
        #12;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", {16'h0, resp_rdata}, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_mem_outs", {mem_addr, mem_wdata}, 32'h0);
        chk("rst_mem_en_wr", {30'h0, mem_enable, mem_wr}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++) begin
            poke(16'(i), 8'($urandom));
            poke(16'hFFC0 + 16'(i), 8'($urandom));
        end
        poke(16'h0010, 8'hAB); poke(16'h0011, 8'hCD);
        poke(16'h0012, 8'hEF); poke(16'h0013, 8'h77);
        poke(16'hFFFF, 8'h5A); poke(16'h0000, 8'hA5);

        do_req(1'b0, 16'h0010, 16'h0, 1'b0, 1'b0);
        do_req(1'b0, 16'h0011, 16'h0, 1'b0, 1'b0);
        do_req(1'b1, 16'h0011, 16'h1234, 1'b0, 1'b0);
        @(negedge clk);
        chk("ustore_b10", {24'h0, mem[16'h0010]}, 32'hAB);
        chk("ustore_b11", {24'h0, mem[16'h0011]}, 32'h12);
        chk("ustore_b12", {24'h0, mem[16'h0012]}, 32'h34);
        chk("ustore_b13", {24'h0, mem[16'h0013]}, 32'h77);
        do_req(1'b0, 16'hFFFF, 16'h0, 1'b0, 1'b0);
        do_req(1'b1, 16'h0020, 16'h1111, 1'b0, 1'b1);
        do_req(1'b1, 16'h0025, 16'h2222, 1'b0, 1'b1);
        do_req(1'b0, 16'h0024, 16'h0, 1'b1, 1'b0);

        // Instance that rejects odd addresses.
        na_en_seen = 1'b0;
        @(negedge clk);
        na_req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0011;
        @(negedge clk);
        na_req_valid = 1'b0;
        chk("na_resp_valid", {31'h0, na_resp_valid}, 32'h1);
        chk("na_resp_err", {31'h0, na_resp_err}, 32'h1);
        chk("na_resp_rdata", {16'h0, na_resp_rdata}, 32'h0);
        @(negedge clk);
        chk("na_resp_one_cycle", {31'h0, na_resp_valid}, 32'h0);
        chk("na_ready_back", {31'h0, na_req_ready}, 32'h1);
        chk("na_no_mem_enable", {31'h0, na_en_seen}, 32'h0);
        na_req_valid = 1'b1; req_addr = 16'h0010;
        @(negedge clk);
        na_req_valid = 1'b0;
        chk("na_aligned_addr", {15'h0, na_mem_enable, na_mem_addr}, {15'h0, 1'b1, 16'h0010});
        @(negedge clk);
        chk("na_aligned_resp", {14'h0, na_resp_valid, na_resp_err, na_resp_rdata},
            {14'h0, 1'b1, 1'b0, 16'hBEEF});

        // Reset during WR0 of an unaligned store.
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0031; req_wdata = 16'hC3C3;
        @(negedge clk);
        req_valid = 1'b0;
        waitc = 0;
        while (!(mem_enable && mem_wr) && waitc < 10) begin @(negedge clk); waitc++; end
        chk("reached_wr0", {31'h0, mem_enable && mem_wr}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_abort_enable", {30'h0, mem_enable, mem_wr}, 32'h0);
        chk("rst_abort_resp", {31'h0, resp_valid}, 32'h0);
        q.delete();
        trace.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_resp", {31'h0, resp_valid}, 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'h0, req_ready}, 32'h1);
        do_req(1'b0, 16'h0010, 16'h0, 1'b0, 1'b0);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 3) ra = 16'hFFC0 + 16'($urandom_range(0, 63));
            else ra = 16'($urandom_range(0, 61));
            do_req(1'($urandom), ra, 16'($urandom),
                   $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);

        mism = 0;
        for (int i = 0; i < 64; i++) begin
            if (mem[16'(i)] !== ref_mem[16'(i)]) mism++;
            if (mem[16'hFFC0 + 16'(i)] !== ref_mem[16'hFFC0 + 16'(i)]) mism++;
        end
        chk("mem_final_contents", mism, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
